// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port between N producers.
// Optional `ARB_PRIO0_EN gives channel 0 strict priority when the arbiter is idle.
module fifo_wr_arbiter #(
  parameter int N            = 4,
  parameter int DW           = 32,
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req_valid,
  input  logic [N-1:0]           req_last,
  input  logic [N*DW-1:0]        req_data,
  output logic [N-1:0]           req_ready,
  input  logic                   fifo_full,
  output logic                   wr,
  output logic [DW-1:0]          data_in,
  output logic [$clog2(N)-1:0]   grant_id,
  output logic                   busy
);

  localparam int IDW = $clog2(N);
  localparam int BCW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t           state, state_n;
  logic [IDW-1:0]   owner, owner_n;
  logic [IDW-1:0]   rr_ptr, rr_ptr_n;
  logic [BCW-1:0]   beat_cnt, beat_cnt_n;
  logic [7:0]       idle_cnt, idle_cnt_n;

  logic             found;
  logic             prio_win;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   cand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= IDW'(N - 1);
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      rr_ptr   <= rr_ptr_n;
      beat_cnt <= beat_cnt_n;
      idle_cnt <= idle_cnt_n;
    end
  end

  // Search starts just after the last granted channel so every requester is reached within N grants.
  always_comb begin
    found    = 1'b0;
    prio_win = 1'b0;
    winner   = '0;
    cand     = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IDW'((int'(rr_ptr) + i) % N);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
`ifdef ARB_PRIO0_EN
    if (req_valid[0]) begin
      found    = 1'b1;
      winner   = '0;
      prio_win = 1'b1;
    end
`endif
  end

  always_comb begin
    req_ready = '0;
    wr        = 1'b0;
    data_in   = '0;
    busy      = 1'b0;
    grant_id  = '0;
    if (state == BURST) begin
      busy             = 1'b1;
      grant_id         = owner;
      req_ready[owner] = ~fifo_full;
      wr               = req_valid[owner] & ~fifo_full;
      if (wr) begin
        data_in = req_data[int'(owner)*DW +: DW];
      end
    end
  end

  // A full FIFO counts as a stall, so a blocked owner can still time out and lose the grant.
  always_comb begin
    state_n    = state;
    owner_n    = owner;
    rr_ptr_n   = rr_ptr;
    beat_cnt_n = beat_cnt;
    idle_cnt_n = idle_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_n    = BURST;
          owner_n    = winner;
          beat_cnt_n = '0;
          idle_cnt_n = '0;
          if (!prio_win) begin
            rr_ptr_n = winner;
          end
        end
      end
      BURST: begin
        if (wr) begin
          beat_cnt_n = beat_cnt + 1'b1;
          idle_cnt_n = '0;
          if (req_last[owner] || (beat_cnt == BCW'(MAX_BURST - 1))) begin
            state_n = IDLE;
          end
        end else if (idle_cnt == 8'(IDLE_TIMEOUT - 1)) begin
          state_n = IDLE;
        end else if (idle_cnt != 8'hFF) begin
          idle_cnt_n = idle_cnt + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: per-channel beat queues plus a grant-level reference model.
// Honours `ARB_PRIO0_EN the same way the design does.
module tb_fifo_wr_arbiter;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int MAXB = 8;
  localparam int TO   = 8;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_last;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              fifo_full;
  logic              wr;
  logic [DW-1:0]     data_in;
  logic [1:0]        grant_id;
  logic              busy;

  int totalChecks;
  int badChecks;

  logic [DW:0] beatQ [N][$];
  int seqNum;

  int mBusy;
  int mOwner;
  int mLast;
  int mBeats;
  int mIdleRun;

  fifo_wr_arbiter #(
    .N(N), .DW(DW), .MAX_BURST(MAXB), .IDLE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
    .wr(wr), .data_in(data_in), .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Producers present the head of their queue; queues refill with fresh bursts when drained.
  task automatic applyStimulus(input int density, input int fullPct);
    int n;
    for (int c = 0; c < N; c++) begin
      if (beatQ[c].size() == 0) begin
        n = $urandom_range(1, 12);
        for (int k = 0; k < n; k++) begin
          seqNum++;
          beatQ[c].push_back({((k == n - 1) && ($urandom_range(0, 3) != 0)),
                              4'(c), 28'(seqNum)});
        end
      end
      req_valid[c] = ($urandom_range(0, 9) < density);
      req_data[c*DW +: DW] = beatQ[c][0][DW-1:0];
      req_last[c] = beatQ[c][0][DW];
    end
    fifo_full = ($urandom_range(0, 99) < fullPct);
  endtask

  task automatic modelStep(input logic beat);
    int w;
    logic prio;
    logic [DW:0] popped;
    if (mBusy == 0) begin
      w = -1;
      prio = 1'b0;
`ifdef ARB_PRIO0_EN
      if (req_valid[0]) begin
        w = 0;
        prio = 1'b1;
      end
`endif
      for (int k = 1; k <= N; k++) begin
        if (w < 0 && req_valid[(mLast + k) % N]) w = (mLast + k) % N;
      end
      if (w >= 0) begin
        mBusy = 1;
        mOwner = w;
        mBeats = 0;
        mIdleRun = 0;
        if (!prio) mLast = w;
      end
    end else if (beat) begin
      popped = beatQ[mOwner].pop_front();
      mBeats++;
      mIdleRun = 0;
      if (popped[DW] || mBeats == MAXB) mBusy = 0;
    end else begin
      mIdleRun++;
      if (mIdleRun == TO) mBusy = 0;
    end
  endtask

  initial begin
    int densTab [6];
    int fullTab [6];
    logic expWr;
    logic [N-1:0] expReady;
    logic [DW-1:0] expData;
    logic pendingRelease;
    int resetsDone;

    densTab = '{10, 8, 5, 2, 9, 6};
    fullTab = '{0, 20, 10, 30, 5, 50};
    totalChecks = 0;
    badChecks = 0;
    seqNum = 0;
    resetsDone = 0;
    rst_n = 1'b0;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    fifo_full = 1'b0;
    mBusy = 0;
    mOwner = 0;
    mLast = N - 1;
    mBeats = 0;
    mIdleRun = 0;

    #12;
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstWr", 32'(wr), 32'd0);
    checkOutput("rstReady", 32'(req_ready), 32'd0);
    checkOutput("rstData", data_in, 32'd0);
    checkOutput("rstGrant", 32'(grant_id), 32'd0);
    pendingRelease = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (pendingRelease) begin
        rst_n = 1'b1;
        pendingRelease = 1'b0;
      end
      applyStimulus(densTab[cyc / 500], fullTab[cyc / 500]);
      #1;
      expWr = (mBusy != 0) && req_valid[mOwner] && !fifo_full;
      expReady = '0;
      if (mBusy != 0) expReady[mOwner] = !fifo_full;
      expData = expWr ? beatQ[mOwner][0][DW-1:0] : '0;
      checkOutput("busy", 32'(busy), 32'(mBusy));
      checkOutput("wr", 32'(wr), 32'(expWr));
      checkOutput("ready", 32'(req_ready), 32'(expReady));
      checkOutput("data", data_in, expData);
      if (mBusy != 0) checkOutput("grant", 32'(grant_id), 32'(mOwner));

      // Abandon a burst on its 4th beat with an asynchronous reset pulse.
      if (resetsDone < 2 && cyc > 800 * (resetsDone + 1) && expWr && mBeats == 3) begin
        #1 rst_n = 1'b0;
        #1;
        checkOutput("asyncWr", 32'(wr), 32'd0);
        checkOutput("asyncBusy", 32'(busy), 32'd0);
        checkOutput("asyncReady", 32'(req_ready), 32'd0);
        @(posedge clk);
        mBusy = 0;
        mLast = N - 1;
        pendingRelease = 1'b1;
        resetsDone++;
      end else begin
        @(posedge clk);
        modelStep(expWr);
      end
    end

    checkOutput("resetsHit", 32'(resetsDone), 32'd2);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one 32-bit pixel FIFO (16-deep, write side `wr`/`data_in`/`fifo_full`) between N upstream image-line producers.
- Grants one producer at a time for a burst, ending on a producer-marked last beat, MAX_BURST beats, or an idle timeout.
- Routes that producer's beats into the FIFO write port and reports the granted channel id alongside.

Parameters:
- N, 4, number of requesting producers (2..8).
- DW, 32, data width; matches the FIFO data width.
- MAX_BURST, 8, maximum beats per grant (1..16).
- IDLE_TIMEOUT, 8, consecutive owner-idle cycles before forced release (1..255).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  N  per-producer beat valid.
- req_last  input  N  per-producer end-of-burst marker, qualified by req_valid.
- req_data  input  N*DW  flattened producer data; channel i occupies bits [i*DW +: DW].
- req_ready  output  N  per-producer accept; at most one bit high.
- fifo_full  input  1  FIFO full status.
- wr  output  1  FIFO write strobe.
- data_in  output  DW  FIFO write data.
- grant_id  output  clog2(N)  current owner index; valid while busy=1.
- busy  output  1  high in BURST state.

Behaviour:
- States: IDLE, BURST (registered). Registered fields: owner, rr_ptr (last granted channel), beat_cnt (clog2(MAX_BURST+1) bits), idle_cnt (8 bits).
- Reset (async, immediate):
  - state=IDLE, owner=0, rr_ptr=N-1 (so channel 0 wins first), beat_cnt=0, idle_cnt=0.
  - Outputs: req_ready=0, wr=0, data_in=0, busy=0, grant_id=0.
  - Reset asserted mid-burst drops wr and req_ready in the same cycle; the partial burst is abandoned.
- IDLE:
  - Search req_valid starting at rr_ptr+1, wrapping modulo N; first set bit wins.
  - On a win: owner<=winner, rr_ptr<=winner, beat_cnt<=0, idle_cnt<=0, state<=BURST.
  - No data moves in the arbitration cycle: 1-cycle grant latency.
  - No request present: stay in IDLE, registers hold.
- BURST:
  - Outputs (combinational):
    - req_ready[owner] = ~fifo_full; all other req_ready bits = 0.
    - wr = req_valid[owner] & ~fifo_full.
    - data_in = req_data[owner] when wr=1, else 0.
    - busy=1, grant_id=owner.
  - Beat: wr=1 → beat_cnt+1 and idle_cnt<=0.
  - Stall: no beat (valid low or fifo_full) → idle_cnt+1, saturating at 255. fifo_full stalls count toward the timeout.
  - End of burst, state<=IDLE on any of:
    - beat with req_last[owner]=1;
    - beat that makes beat_cnt == MAX_BURST;
    - idle_cnt reaching IDLE_TIMEOUT-1 on a non-beat cycle.
  - After release, the next winner is searched from owner+1, which guarantees fairness.
- Simultaneous events:
  - Last beat coinciding with MAX_BURST counts as one release.
  - fifo_full blocks the beat; the last-beat decision is deferred to the next accepted beat.
- Never writes when fifo_full=1, so the FIFO never sees an overflow attempt from this block.
- Non-owner producers wait with ready low; they must hold data stable while valid is high.

Optional Feature:
- Macro: ARB_PRIO0_EN.
- Defined:
  - Channel 0 is strict-priority in IDLE: req_valid[0]=1 wins regardless of rr_ptr.
  - rr_ptr is not updated by a priority grant, so round-robin order among channels 1..N-1 is preserved.
  - A burst in progress is never pre-empted.
- Undefined: pure round-robin as above.

Test Plan:
- Reset, then req_valid=4'b0001 with 3 beats (last on the 3rd), fifo_full=0 → busy rises 1 cycle after valid; wr high for 3 consecutive cycles with channel-0 data in order; grant_id=0; IDLE afterwards.
- All 4 channels continuously valid, no req_last, MAX_BURST=8 → grant order 0,1,2,3,0; exactly 8 beats per grant; 1 idle arbitration cycle between bursts.
- Owner channel 2 sends 2 beats then drops valid, IDLE_TIMEOUT=8 → release after 8 idle cycles; channel 3 (waiting) granted next.
- fifo_full held high for 5 cycles mid-burst on channel 1 → wr=0 and req_ready=0 throughout; no beat lost or duplicated; burst resumes when full drops. With a 6-cycle full (timeout 8) the grant is kept.
- rst_n pulsed low during the 4th beat of a burst → wr, busy, req_ready go 0 asynchronously; after release channel 0 wins first.
- ARB_PRIO0_EN defined, channels 0 and 2 valid, rr_ptr=0 → channel 0 granted again; after its burst ends and only channel 2 remains, channel 2 granted.
